// File: rtl/chunked_addsub_pkg.sv
// Shared definitions for the chunk-serial adder/subtractor: FSM encoding,
// operation modes and parameter helpers.
package chunked_addsub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // WIDTH must be split into whole CHUNK-bit slices
    function automatic bit params_legal(int unsigned width, int unsigned chunk);
        return (chunk >= 1) && (chunk <= width) && ((width % chunk) == 0);
    endfunction

    // Index width for a counter over n chunks (at least one bit)
    function automatic int unsigned idx_width(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/chunked_addsub_chunk_adder.sv
// Combinational CHUNK-bit ripple slice; also exposes the carry into its MSB
// so the top can derive signed overflow on the final chunk.
module chunked_addsub_chunk_adder #(
    parameter int unsigned CHUNK = 2
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum_c,
    output logic             cout_c,
    output logic             cmsb_c
);

    logic [CHUNK:0] carry;

    always_comb begin
        carry    = '0;
        sum_c    = '0;
        carry[0] = cin;
        for (int unsigned i = 0; i < CHUNK; i++) begin
            sum_c[i]     = a[i] ^ b[i] ^ carry[i];
            carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
    end

    assign cout_c = carry[CHUNK];
    assign cmsb_c = carry[CHUNK - 1];

endmodule

// File: rtl/chunked_addsub.sv
// Sequential WIDTH-bit adder/subtractor that pushes CHUNK bits per clock
// through one shared ripple slice, with accumulate mode and start/busy/done.
module chunked_addsub
    import chunked_addsub_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic             acc_en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             carry_out,
    output logic             overflow
);

    localparam int unsigned N  = WIDTH / CHUNK;
    localparam int unsigned KW = idx_width(N);

    if (!params_legal(WIDTH, CHUNK)) begin : g_bad_params
        $error("chunked_addsub: WIDTH must be a positive multiple of CHUNK");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic             carry_q, carry_d;
    logic [KW-1:0]    k_q, k_d;
    logic             busy_d, done_d, carry_out_d, overflow_d;
    logic [WIDTH-1:0] out_d;
    logic             last_c;

    logic [CHUNK-1:0] sl_a, sl_b, sl_sum_c;
    logic             sl_cout_c, sl_cmsb_c;

    assign last_c = (k_q == KW'(N - 1));

    // Route chunk k of each operand into the shared slice
    always_comb begin
        sl_a = '0;
        sl_b = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (k_q == KW'(i)) begin
                sl_a = op_a_q[i*CHUNK +: CHUNK];
                sl_b = op_b_q[i*CHUNK +: CHUNK];
            end
        end
    end

    chunked_addsub_chunk_adder #(.CHUNK(CHUNK)) u_chunk_adder (
        .a      (sl_a),
        .b      (sl_b),
        .cin    (carry_q),
        .sum_c  (sl_sum_c),
        .cout_c (sl_cout_c),
        .cmsb_c (sl_cmsb_c)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (start)  state_d = ST_RUN;
            ST_RUN:  if (last_c) state_d = ST_DONE;
            ST_DONE:             state_d = ST_IDLE;
            default:             state_d = ST_IDLE;
        endcase
    end

    // Output and datapath next values; results publish only on the final chunk
    always_comb begin
        busy_d      = (state_d == ST_RUN);
        done_d      = (state_d == ST_DONE);
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        carry_d     = carry_q;
        k_d         = k_q;
        shadow_d    = shadow_q;
        out_d       = out;
        carry_out_d = carry_out;
        overflow_d  = overflow;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_a_d  = acc_en ? out : a;
                    op_b_d  = (mode == MODE_ADD) ? b : ~b;
                    carry_d = (mode == MODE_SUB);
                    k_d     = '0;
                end
            end
            ST_RUN: begin
                for (int unsigned i = 0; i < N; i++) begin
                    if (k_q == KW'(i)) shadow_d[i*CHUNK +: CHUNK] = sl_sum_c;
                end
                carry_d = sl_cout_c;
                k_d     = k_q + KW'(1);
                if (last_c) begin
                    out_d       = shadow_d;
                    carry_out_d = sl_cout_c;
                    overflow_d  = sl_cmsb_c ^ sl_cout_c;
                end
            end
            default: ;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a_q    <= '0;
            op_b_q    <= '0;
            shadow_q  <= '0;
            carry_q   <= 1'b0;
            k_q       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            out       <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            shadow_q  <= shadow_d;
            carry_q   <= carry_d;
            k_q       <= k_d;
            busy      <= busy_d;
            done      <= done_d;
            out       <= out_d;
            carry_out <= carry_out_d;
            overflow  <= overflow_d;
        end
    end

endmodule

// File: tb/tb_chunked_addsub.sv
// Scoreboard bench: directed and random operations on an 8/2 instance plus a
// random sweep over other WIDTH/CHUNK combinations, all checked against an
// arithmetic reference model.
module tb_chunked_addsub;

    typedef struct {
        logic [31:0] res;
        bit          c;
        bit          v;
        int          t0;
    } exp_t;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int sw_fin = 0;

    logic clk      = 1'b0;
    logic rst_n    = 1'b0;
    logic sw_rst_n = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired at cycle %0d", name, cyc);
    endtask

    // Reference: unsigned/signed arithmetic on the whole operands
    function automatic exp_t ref_op(input int w, input bit m, input logic [31:0] av, input logic [31:0] bv);
        exp_t   e;
        longint md, ua, ub, sa, sb, full, sr;
        md = longint'(1) << w;
        ua = longint'(av) % md;
        ub = longint'(bv) % md;
        sa = (ua >= md / 2) ? ua - md : ua;
        sb = (ub >= md / 2) ? ub - md : ub;
        if (!m) begin
            full = ua + ub;
            e.c  = (full >= md);
            sr   = sa + sb;
        end else begin
            full = ua - ub + md;
            e.c  = (ua >= ub);
            sr   = sa - sb;
        end
        e.res = 32'(full % md);
        e.v   = (sr >= md / 2) || (sr < -(md / 2));
        e.t0  = 0;
        return e;
    endfunction

    task automatic check_result(input string tag, input exp_t e, input logic [31:0] o, input bit co,
                                input bit ov, input int lat, input int bcnt, input int n);
        chk({tag, "_out"}, longint'(o), longint'(e.res));
        chk({tag, "_carry_out"}, longint'(co), longint'(e.c));
        chk({tag, "_overflow"}, longint'(ov), longint'(e.v));
        chk({tag, "_done_latency"}, longint'(lat), longint'(n + 1));
        chk({tag, "_busy_cycles"}, longint'(bcnt), longint'(n));
    endtask

    // ---------------- main 8/2 instance ----------------
    logic       start = 1'b0, mode = 1'b0, acc_en = 1'b0;
    logic [7:0] a = '0, b = '0, out;
    logic       busy, done, carry_out, overflow;
    exp_t       mq[$];
    logic [31:0] m_last = '0;

    chunked_addsub #(.WIDTH(8), .CHUNK(2)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .mode      (mode),
        .acc_en    (acc_en),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .out       (out),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    always @(negedge clk) begin : mon_main
        exp_t e;
        int   bc;
        if (!rst_n) begin
            bc = 0;
        end else begin
            if (busy) bc++;
            if (done) begin
                if (mq.size() == 0) begin
                    timeout_fail("main_unexpected_done");
                end else begin
                    e = mq.pop_front();
                    check_result("main", e, 32'(out), carry_out, overflow, cyc + 1 - e.t0, bc, 4);
                end
                bc = 0;
            end
        end
    end

    // Wait for IDLE, present one request, scoreboard its expectation
    task automatic issue(input bit m, input bit acc, input logic [7:0] av, input logic [7:0] bv);
        exp_t e;
        int   n;
        @(negedge clk);
        n = 0;
        while ((busy || done) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) timeout_fail("main_idle_wait");
        start  = 1'b1;
        mode   = m;
        acc_en = acc;
        a      = av;
        b      = bv;
        e      = ref_op(8, m, acc ? m_last : 32'(av), 32'(bv));
        m_last = e.res;
        @(posedge clk);
        #1;
        e.t0 = cyc;
        mq.push_back(e);
        start  = 1'b0;
        mode   = 1'($urandom);
        acc_en = 1'($urandom);
        a      = 8'($urandom);
        b      = 8'($urandom);
    endtask

    initial begin : main_stim
        int n;
        #12;
        chk("rst_out", longint'(out), 0);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_done", longint'(done), 0);
        chk("rst_carry_out", longint'(carry_out), 0);
        chk("rst_overflow", longint'(overflow), 0);
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        sw_rst_n = 1'b1;

        issue(1'b0, 1'b0, 8'h69, 8'hB6);
        issue(1'b1, 1'b0, 8'h0A, 8'h57);
        issue(1'b0, 1'b0, 8'h7F, 8'h01);
        issue(1'b0, 1'b0, 8'h0A, 8'h57);
        issue(1'b0, 1'b1, 8'hFF, 8'h10);
        issue(1'b1, 1'b1, 8'hFF, 8'h71);

        // start held high through every RUN and DONE cycle must be ignored
        issue(1'b0, 1'b0, 8'h3C, 8'h45);
        start = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("hold_after_ignored_start", longint'(out), longint'(m_last));
        chk("no_restart_busy", longint'(busy), 0);

        // asynchronous reset with k = 2 mid-RUN
        issue(1'b1, 1'b0, 8'h12, 8'h34);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrun_rst_out", longint'(out), 0);
        chk("midrun_rst_busy", longint'(busy), 0);
        chk("midrun_rst_done", longint'(done), 0);
        chk("midrun_rst_overflow", longint'(overflow), 0);
        mq.delete();
        m_last = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        issue(1'b0, 1'b1, 8'hAA, 8'h25);
        issue(1'b0, 1'b0, 8'h80, 8'h80);

        for (int i = 0; i < 40; i++)
            issue(1'($urandom), ($urandom_range(0, 3) == 0), 8'($urandom), 8'($urandom));

        n = 0;
        while (mq.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("main_queue_drained", longint'(mq.size()), 0);
        n = 0;
        while (sw_fin != 4 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (sw_fin != 4) timeout_fail("sweep_completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // ---------------- parameter sweep ----------------
    localparam int SW_W[4] = '{8, 8, 8, 16};
    localparam int SW_C[4] = '{1, 4, 8, 4};

    for (genvar g = 0; g < 4; g++) begin : g_sw
        localparam int W  = SW_W[g];
        localparam int C  = SW_C[g];
        localparam int NN = W / C;

        logic         s_start = 1'b0, s_mode = 1'b0, s_acc = 1'b0;
        logic [W-1:0] s_a = '0, s_b = '0, s_out;
        logic         s_busy, s_done, s_co, s_ov;
        exp_t         q[$];
        logic [31:0]  last = '0;

        chunked_addsub #(.WIDTH(W), .CHUNK(C)) u_sw (
            .clk       (clk),
            .rst_n     (sw_rst_n),
            .start     (s_start),
            .mode      (s_mode),
            .acc_en    (s_acc),
            .a         (s_a),
            .b         (s_b),
            .busy      (s_busy),
            .done      (s_done),
            .out       (s_out),
            .carry_out (s_co),
            .overflow  (s_ov)
        );

        always @(negedge clk) begin : mon
            exp_t e;
            int   bc;
            if (!sw_rst_n) begin
                bc = 0;
            end else begin
                if (s_busy) bc++;
                if (s_done) begin
                    if (q.size() == 0) begin
                        timeout_fail($sformatf("sw%0d_unexpected_done", g));
                    end else begin
                        e = q.pop_front();
                        check_result($sformatf("sw%0d_w%0d_c%0d", g, W, C), e, 32'(s_out), s_co, s_ov,
                                     cyc + 1 - e.t0, bc, NN);
                    end
                    bc = 0;
                end
            end
        end

        initial begin : stim
            exp_t e;
            int   n;
            wait (sw_rst_n === 1'b1);
            for (int i = 0; i < 30; i++) begin
                @(negedge clk);
                n = 0;
                while ((s_busy || s_done) && n < 64) begin
                    @(negedge clk);
                    n++;
                end
                if (n >= 64) timeout_fail($sformatf("sw%0d_idle_wait", g));
                s_mode  = 1'($urandom);
                s_acc   = ($urandom_range(0, 3) == 0);
                s_a     = W'($urandom);
                s_b     = W'($urandom);
                e       = ref_op(W, s_mode, s_acc ? last : 32'(s_a), 32'(s_b));
                last    = e.res;
                s_start = 1'b1;
                @(posedge clk);
                #1;
                e.t0 = cyc;
                q.push_back(e);
                s_start = 1'b0;
                s_mode  = 1'($urandom);
                s_acc   = 1'($urandom);
                s_a     = W'($urandom);
                s_b     = W'($urandom);
            end
            n = 0;
            while (q.size() != 0 && n < 64) begin
                @(negedge clk);
                n++;
            end
            chk($sformatf("sw%0d_queue_drained", g), longint'(q.size()), 0);
            sw_fin++;
        end
    end

endmodule
